cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
- N-stage CIC interpolator; the transmit-side counterpart of the receive-side CIC decimator in the same SDR chain.
- Low-rate samples pass through N comb stages (differential delay M) into a one-deep holding buffer.
- The buffer is zero-stuffed by R and fed to N integrators clocked by the high-rate enable.
- Sits between baseband sample generation and the DAC/upconverter datapath.

Parameters:
- IW, 5, input sample width (signed two's complement).
- OW, 14, output width; must satisfy OW <= WI.
- R, 8, interpolation ratio; must satisfy R >= N+2.
- N, 3, number of comb and integrator stages.
- M, 1, comb differential delay (1 or 2).
- Derived WI = IW + N*$clog2(R*M): internal full-precision width, used by every comb and integrator register.

Ports:
- i_clk  in  1  single clock, all logic rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_ce  in  1  high-rate output strobe; one output sample per strobe.
- i_data  in  IW  signed low-rate input sample.
- i_valid  in  1  i_data valid.
- o_in_ready  out  1  block accepts i_data this cycle.
- o_data  out  OW  signed interpolated output.
- o_ready  out  1  o_data valid (one-cycle pulse).
- o_underflow  out  1  one-cycle pulse when a zero is injected because no sample was buffered.

Behaviour:
- Reset (i_reset low, asynchronous) clears all comb/integrator registers, comb delay lines, buffer, phase counter and valid bits; state = IDLE; o_data=0, o_ready=0, o_in_ready=0 during reset, o_underflow=0. Reset mid-operation discards all in-flight data; no output pulse in the following cycle.
- Accept: i_valid && o_in_ready. Input is sign-extended to WI.
- o_in_ready = 1 when the buffer is empty and no sample is in the comb pipeline. Independent of i_ce.
- Comb pipeline: one register stage per comb, advanced every clk by a per-stage valid bit. Stage k output = x - x[-M], where the delay line shifts only when that stage's valid is set. Accepted sample reaches the buffer N clocks after accept.
- Phase counter p (0..R-1): increments on i_ce in state RUN and wraps R-1 -> 0. Held at 0 in IDLE.
- FSM:
  - IDLE -> RUN on the first i_ce with the buffer full. That strobe injects the buffered value (p=0), empties the buffer and sets p=1.
  - RUN, i_ce at p=0 with buffer full: inject the buffer and empty it.
  - RUN, i_ce at p=0 with buffer empty: inject 0 and pulse o_underflow on the next cycle. Stay in RUN.
  - RUN, i_ce at p!=0: inject 0 (zero-stuff).
  - No RUN -> IDLE transition except by reset.
- Buffer fill and drain in the same cycle (p=0, i_ce, comb output arriving): drain the old value, load the new one; buffer stays full.
- Integrators: N registered stages, all updated only on i_ce; stage k <= stage k + stage(k-1) previous value. Wrap-around modulo 2^WI is intentional (CIC property); no saturation.
- Output: o_ready = i_ce delayed one clk. o_data registered on the same edge = top OW bits of the last integrator (truncation unless the optional feature is enabled). Impulse latency is N i_ce strobes from injection.
- DC gain = (R*M)^N / R.

Optional Feature:
- Macro CIC_INTERP_ROUND_EN.
- Defined: when OW < WI, o_data = round-half-up of the WI-bit value to OW MSBs (add 1 at bit WI-OW-1, then slice). The add is modulo 2^WI with no saturation.
- Undefined: plain truncation (drop the LSBs).
- When OW == WI, both builds are identical.

Test Plan (defaults: R=8, N=3, M=1, IW=5, OW=14, i_ce tied high):
- Reset release, no i_valid for 20 clk -> o_in_ready=1 after reset; o_ready=0, o_data=0, o_underflow=0 (IDLE).
- Constant i_data=1, i_valid=1 continuously -> o_data settles to 64 after at least 3*R strobes and holds; o_underflow never pulses.
- Constant i_data=-16 -> o_data settles to -1024; constant i_data=15 -> settles to 960.
- Single impulse i_data=1, then zeros -> 24 output samples 1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1,0,0 (after N-strobe latency); their sum is 512.
- After RUN, stop i_valid -> exactly one o_underflow pulse per R strobes; o_data decays to 0 for zero input.
- Assert i_reset low mid-stream for 1 clk -> all outputs 0 next cycle, state IDLE; restarting with constant 1 gives the same response as the second scenario.

Source files
------------

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator (transmit side of the SDR chain).
// Low-rate samples run through N comb stages (differential delay M) into a
// one-deep holding buffer. The buffer is zero-stuffed by R and fed to N
// integrators that advance on the high-rate strobe i_ce.
// Optional build macro: CIC_INTERP_ROUND_EN selects round-half-up on the
// output slice instead of plain truncation (only matters when OW < WI).
//
// Handshake: a sample is taken on a rising edge where i_valid && o_in_ready.
// o_in_ready depends only on internal state (never on i_valid or i_ce).
// o_ready is a one-cycle pulse marking o_data valid; there is no back-pressure
// on the output side.
module cic_interpolator #(
    parameter int IW = 5,
    parameter int OW = 14,
    parameter int R  = 8,
    parameter int N  = 3,
    parameter int M  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_in_ready,
    output logic [OW-1:0] o_data,
    output logic          o_ready,
    output logic          o_underflow,
    output logic          o_state
);
    localparam int WI = IW + N * $clog2(R * M);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(R - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WI-1:0] comb_q    [N];
    logic [N-1:0]  comb_v;
    logic [WI-1:0] comb_dly  [N][M];
    logic [WI-1:0] comb_in   [N];
    logic [N-1:0]  comb_in_v;
    logic [WI-1:0] buf_q;
    logic          buf_full;
    logic [PW-1:0] phase;
    logic [0:0]    state;
    logic [WI-1:0] integ     [N];
    logic [WI-1:0] inject;
    logic [WI-1:0] out_full;
    logic          accept;
    logic          strobe;
    logic          take_buf;
    logic          underflow_now;

    assign o_state = state;

    // Ready only when nothing is buffered or in flight; forced low in reset.
    assign o_in_ready = i_reset && !buf_full && (comb_v == '0);

    // Comb stage inputs, strobe qualification and the value injected this strobe.
    always_comb begin
        accept       = i_valid && o_in_ready;
        comb_in[0]   = {{(WI-IW){i_data[IW-1]}}, i_data};
        comb_in_v[0] = accept;
        for (int k = 1; k < N; k++) begin
            comb_in[k]   = comb_q[k-1];
            comb_in_v[k] = comb_v[k-1];
        end
        // An i_ce in IDLE with an empty buffer produces no output sample.
        strobe        = i_ce && ((state == ST_RUN) || buf_full);
        take_buf      = strobe && (phase == '0) && buf_full;
        underflow_now = i_ce && (state == ST_RUN) && (phase == '0) && !buf_full;
        inject        = take_buf ? buf_q : '0;
    end

`ifdef CIC_INTERP_ROUND_EN
    if (WI > OW) begin : g_round
        localparam logic [WI-1:0] HALF_LSB = WI'(1) << (WI - OW - 1);
        assign out_full = integ[N-1] + HALF_LSB;
    end else begin : g_no_round
        assign out_full = integ[N-1];
    end
`else
    assign out_full = integ[N-1];
`endif

    // Comb pipeline: each stage computes x - x[-M]; its delay line only moves on valid data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            comb_v <= '0;
            for (int k = 0; k < N; k++) begin
                comb_q[k] <= '0;
                for (int j = 0; j < M; j++) comb_dly[k][j] <= '0;
            end
        end else begin
            comb_v <= comb_in_v;
            for (int k = 0; k < N; k++) begin
                if (comb_in_v[k]) begin
                    comb_q[k]      <= comb_in[k] - comb_dly[k][M-1];
                    comb_dly[k][0] <= comb_in[k];
                    for (int j = 1; j < M; j++) comb_dly[k][j] <= comb_dly[k][j-1];
                end
            end
        end
    end

    // Holding buffer: a load in the same cycle as a drain wins, so it stays full.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
        end else if (comb_v[N-1]) begin
            buf_q    <= comb_q[N-1];
            buf_full <= 1'b1;
        end else if (take_buf) begin
            buf_full <= 1'b0;
        end
    end

    // Control FSM and zero-stuffing phase counter; only reset leaves RUN.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            phase <= '0;
        end else if (i_ce) begin
            if (state == ST_IDLE) begin
                if (buf_full) begin
                    state <= ST_RUN;
                    phase <= PW'(1);
                end
            end else begin
                phase <= (phase == P_MAX) ? '0 : phase + PW'(1);
            end
        end
    end

    // Integrator cascade: each stage adds the previous stage's old value; wraps modulo 2^WI.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < N; k++) integ[k] <= '0;
        end else if (strobe) begin
            integ[0] <= integ[0] + inject;
            for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Output register: one o_ready pulse per strobe, underflow flagged a cycle later.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data      <= '0;
            o_ready     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_ready     <= strobe;
            o_underflow <= underflow_now;
            if (strobe) o_data <= out_full[WI-1 -: OW];
        end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: self-checking bench for cic_interpolator.
// The reference model works on whole sequences: binomial comb on the accepted
// low-rate samples, zero-stuffing by R, N running sums, N-strobe delay.
module tb_cic_interpolator;
    localparam int IW = 5;
    localparam int OW = 14;
    localparam int R  = 8;
    localparam int N  = 3;
    localparam int M  = 1;
    localparam int WI = IW + N * $clog2(R * M);

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_ce = 1'b1;
    logic [IW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_in_ready;
    logic [OW-1:0] o_data;
    logic          o_ready;
    logic          o_underflow;
    logic          o_state;

    int n_checks = 0;
    int n_fail = 0;
    int stray_uf = 0;

    logic [IW-1:0] stim_q[$];
    logic [IW-1:0] acc_q[$];
    logic [OW-1:0] got_q[$];
    logic [OW-1:0] exp_q[$];
    bit            got_uf_q[$];
    bit            exp_uf_q[$];

    cic_interpolator #(.IW(IW), .OW(OW), .R(R), .N(N), .M(M)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
        .i_valid(i_valid), .o_in_ready(o_in_ready), .o_data(o_data),
        .o_ready(o_ready), .o_underflow(o_underflow), .o_state(o_state)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Expected output stream for nout strobes from the accepted samples in acc_q.
    function automatic void build_model(input int nout);
        longint v[];
        longint c;
        longint y;
        logic [WI-1:0] w;
        v = new[nout];
        foreach (v[i]) v[i] = 0;
        for (int m = 0; m * R < nout; m++) begin
            c = 0;
            if (m < acc_q.size()) begin
                for (int j = 0; j <= N; j++) begin
                    if (m - j * M >= 0)
                        c += ((j % 2) ? -1 : 1) * binom(N, j) * longint'($signed(acc_q[m - j * M]));
                end
            end
            v[m * R] = c;
        end
        for (int t = 0; t < N; t++)
            for (int i = 1; i < nout; i++) v[i] += v[i-1];
        exp_q.delete();
        exp_uf_q.delete();
        for (int k = 0; k < nout; k++) begin
            y = (k >= N) ? v[k - N] : 0;
            w = y[WI-1:0];
`ifdef CIC_INTERP_ROUND_EN
            if (OW < WI) w = w + (WI'(1) << (WI - OW - 1));
`endif
            exp_q.push_back(w[WI-1 -: OW]);
            exp_uf_q.push_back((k > 0) && (k % R == 0) && (k / R >= acc_q.size()));
        end
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        stim_q.delete(); acc_q.delete(); got_q.delete(); got_uf_q.delete();
        stray_uf = 0;
    endtask

    // Driver + output capture: feeds stim_q with valid/ready, records every o_ready sample.
    task automatic run_stream(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clk);
            if (o_ready) begin
                got_q.push_back(o_data);
                got_uf_q.push_back(o_underflow);
            end else if (o_underflow) begin
                stray_uf++;
            end
            if (stim_q.size() > 0) begin
                i_valid = 1'b1;
                i_data  = stim_q[0];
            end else begin
                i_valid = 1'b0;
                i_data  = '0;
            end
            #1;
            if (i_valid && o_in_ready) begin
                acc_q.push_back(i_data);
                void'(stim_q.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_in_ready, o_ready, o_underflow, o_state, o_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ordy=%b uf=%b st=%b data=%0d required all 0",
                     o_in_ready, o_ready, o_underflow, o_state, o_data);
        end
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_in_ready !== 1'b1 || o_ready !== 1'b0 || o_underflow !== 1'b0 ||
                o_state !== 1'b0 || o_data !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle[%0d]: got in_rdy=%b ordy=%b uf=%b st=%b data=%0d required 1,0,0,0,0",
                         c, o_in_ready, o_ready, o_underflow, o_state, $signed(o_data));
            end
        end
    endtask

    task automatic test_dc(input logic [IW-1:0] val, input int settle);
        int ncyc;
        ncyc = 26 * R;
        do_reset();
        for (int i = 0; i < 40; i++) stim_q.push_back(val);
        run_stream(ncyc);
        build_model(got_q.size());
        n_checks++;
        if (got_q.size() !== ncyc - N - 2) begin
            n_fail++;
            $display("FAIL dc_count(%0d): got %0d outputs required %0d", $signed(val), got_q.size(), ncyc - N - 2);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k] || got_uf_q[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL dc_sample(%0d)[%0d]: got %0d uf=%b required %0d uf=0",
                         $signed(val), k, $signed(got_q[k]), got_uf_q[k], $signed(exp_q[k]));
            end
            if (k >= 3 * R) begin
                n_checks++;
                if ($signed(got_q[k]) !== settle) begin
                    n_fail++;
                    $display("FAIL dc_settled(%0d)[%0d]: got %0d required %0d",
                             $signed(val), k, $signed(got_q[k]), settle);
                end
            end
        end
        n_checks++;
        if (stray_uf !== 0) begin
            n_fail++;
            $display("FAIL dc_underflow: got %0d pulses required 0", stray_uf);
        end
    endtask

    task automatic test_impulse();
        int imp[24] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48,
                        46, 42, 36, 28, 21, 15, 10, 6, 3, 1, 0, 0};
        int sum;
        do_reset();
        stim_q.push_back(5'd1);
        for (int i = 0; i < 9; i++) stim_q.push_back(5'd0);
        run_stream(10 * R);
        build_model(got_q.size());
        sum = 0;
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (N + i >= got_q.size()) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got no sample required %0d", i, imp[i]);
            end else begin
                sum += $signed(got_q[N + i]);
                if ($signed(got_q[N + i]) !== imp[i]) begin
                    n_fail++;
                    $display("FAIL impulse[%0d]: got %0d required %0d", i, $signed(got_q[N + i]), imp[i]);
                end
            end
        end
        n_checks++;
        if (sum !== 512) begin
            n_fail++;
            $display("FAIL impulse_sum: got %0d required 512", sum);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL impulse_model[%0d]: got %0d required %0d", k, $signed(got_q[k]), $signed(exp_q[k]));
            end
        end
    endtask

    task automatic test_random_underflow();
        int got_pulses;
        int exp_pulses;
        do_reset();
        for (int i = 0; i < 10; i++) stim_q.push_back(IW'($urandom_range(0, 31)));
        for (int i = 0; i < 4; i++) stim_q.push_back(5'd0);
        run_stream(22 * R);
        build_model(got_q.size());
        got_pulses = 0;
        exp_pulses = 0;
        for (int k = 0; k < got_q.size(); k++) begin
            got_pulses += got_uf_q[k];
            exp_pulses += exp_uf_q[k];
            n_checks++;
            if (got_q[k] !== exp_q[k] || got_uf_q[k] !== exp_uf_q[k]) begin
                n_fail++;
                $display("FAIL rand_sample[%0d]: got %0d uf=%b required %0d uf=%b",
                         k, $signed(got_q[k]), got_uf_q[k], $signed(exp_q[k]), exp_uf_q[k]);
            end
        end
        n_checks++;
        if (got_pulses !== exp_pulses || stray_uf !== 0 || exp_pulses < 6) begin
            n_fail++;
            $display("FAIL rand_underflow_count: got %0d (+%0d stray) required %0d",
                     got_pulses, stray_uf, exp_pulses);
        end
        n_checks++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== '0 || o_state !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_decay: got last=%0d state=%b required 0 state=1",
                     (got_q.size() > 0) ? $signed(got_q[got_q.size() - 1]) : -1, o_state);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 30; i++) stim_q.push_back(5'd1);
        run_stream(100);
        i_valid = 1'b0;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_in_ready, o_ready, o_underflow, o_state, o_data} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: got rdy=%b ordy=%b uf=%b st=%b data=%0d required all 0",
                     o_in_ready, o_ready, o_underflow, o_state, $signed(o_data));
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b0 || o_underflow !== 1'b0 || o_state !== 1'b0 ||
            o_data !== '0 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_after: got ordy=%b uf=%b st=%b data=%0d in_rdy=%b required 0,0,0,0,1",
                     o_ready, o_underflow, o_state, $signed(o_data), o_in_ready);
        end
        stim_q.delete(); acc_q.delete(); got_q.delete(); got_uf_q.delete();
        stray_uf = 0;
        for (int i = 0; i < 30; i++) stim_q.push_back(5'd1);
        run_stream(200);
        build_model(got_q.size());
        n_checks++;
        if (got_q.size() !== 200 - N - 2) begin
            n_fail++;
            $display("FAIL restart_count: got %0d outputs required %0d", got_q.size(), 200 - N - 2);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k] || (k >= 3 * R && $signed(got_q[k]) !== 64)) begin
                n_fail++;
                $display("FAIL restart_sample[%0d]: got %0d required %0d", k, $signed(got_q[k]), $signed(exp_q[k]));
            end
        end
        n_checks++;
        if (stray_uf !== 0 || got_uf_q.sum() with (int'(item)) !== 0) begin
            n_fail++;
            $display("FAIL restart_underflow: got pulses required none");
        end
    endtask

    initial begin
        test_reset();
        test_dc(5'd1, 64);
        test_dc(5'b10000, -1024);
        test_dc(5'd15, 960);
        test_impulse();
        test_random_underflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
